// File: rtl/fft_pkg.sv
// Shared types and helpers for the streaming FFT output path.
// complex_t is the bin sample format carried between FFT stages.
package fft_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;

  localparam int unsigned FFT_SIZE_DFLT = 32'd16;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Counter/address width for a power-of-two frame length.
  function automatic int fft_addr_bits(input int unsigned n);
    return $clog2(n);
  endfunction

  // Reverse the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int nbits);
    logic [31:0] src;
    logic [31:0] res;
    src = idx;
    res = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        res = {res[30:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_bitrev_unscrambler_if.sv
// Sample stream into and out of the bit-reverse unscrambler.
// master drives bins in, slave is the unscrambler itself.
interface fft_bitrev_unscrambler_if;
  import fft_pkg::*;

  complex_t din;
  logic     din_valid;
  complex_t dout;
  logic     dout_valid;
  logic     dout_first;
  logic     dout_last;
  logic     frame_drop;

  modport master (
    output din,
    output din_valid,
    input  dout,
    input  dout_valid,
    input  dout_first,
    input  dout_last,
    input  frame_drop
  );

  modport slave (
    input  din,
    input  din_valid,
    output dout,
    output dout_valid,
    output dout_first,
    output dout_last,
    output frame_drop
  );

endinterface

// File: rtl/fft_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// The read register clears on reset so the downstream bus idles at zero.
module fft_sdp_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_bitrev_unscrambler.sv
// Ping-pong reorder buffer: bins arrive bit-reversed and leave in natural order
// as one gap-free burst per frame, two edges after the frame's last sample.
module fft_bitrev_unscrambler
  import fft_pkg::*;
#(
  parameter int unsigned FFT_SIZE = FFT_SIZE_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_bitrev_unscrambler_if.slave bus
);

  localparam int            AW      = fft_addr_bits(FFT_SIZE);
  localparam int            DW      = $bits(complex_t);
  localparam logic [AW-1:0] CNT_MAX = AW'(FFT_SIZE - 32'd1);

  logic [AW-1:0] wr_cnt_d,  wr_cnt_q;
  logic          wr_bank_d, wr_bank_q;
  logic [AW-1:0] wr_addr_s;
  logic          wr_done_s;

  rd_state_e     rd_state_d, rd_state_q;
  logic [AW-1:0] rd_cnt_d,   rd_cnt_q;
  logic          rd_bank_d,  rd_bank_q;
  logic          rd_last_s;
  logic          rd_start_s;

  logic          rd_pending_d,   rd_pending_q;
  logic          pend_bank_d,    pend_bank_q;
  logic          frame_drop_d,   frame_drop_q;

  logic          dout_valid_d, dout_valid_q;
  logic          dout_first_d, dout_first_q;
  logic          dout_last_d,  dout_last_q;

  logic [DW-1:0] ram_rdata_s;

  assign wr_done_s = bus.din_valid && (wr_cnt_q == CNT_MAX);
  assign wr_addr_s = AW'(bit_reverse(32'(wr_cnt_q), AW));

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (bus.din_valid) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_done_s) begin
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
    end
  end

  // A waiting bank launches either from idle or in the final address cycle,
  // which is what keeps full-rate output bursts back-to-back.
  assign rd_last_s  = (rd_state_q == RD_READ) && (rd_cnt_q == CNT_MAX);
  assign rd_start_s = rd_pending_q && ((rd_state_q == RD_IDLE) || rd_last_s);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_start_s) begin
          rd_state_d = RD_READ;
          rd_cnt_d   = '0;
          rd_bank_d  = pend_bank_q;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_READ: begin
        if (rd_last_s) begin
          rd_cnt_d = '0;
          if (rd_start_s) begin
            rd_state_d = RD_READ;
            rd_bank_d  = pend_bank_q;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        rd_cnt_d   = '0;
      end
    endcase
  end

  // rd_pending marks a full, unread bank; a second completion on top of it is an overrun.
  always_comb begin
    rd_pending_d = rd_pending_q;
    pend_bank_d  = pend_bank_q;
    frame_drop_d = frame_drop_q;
    if (wr_done_s) begin
      rd_pending_d = 1'b1;
      pend_bank_d  = wr_bank_q;
      if (rd_pending_q && !rd_start_s) begin
        frame_drop_d = 1'b1;
      end else begin
        frame_drop_d = frame_drop_q;
      end
    end else if (rd_start_s) begin
      rd_pending_d = 1'b0;
    end else begin
      rd_pending_d = rd_pending_q;
    end
  end

  always_comb begin
    dout_valid_d = 1'b0;
    dout_first_d = 1'b0;
    dout_last_d  = 1'b0;
    if (rd_state_q == RD_READ) begin
      dout_valid_d = 1'b1;
      dout_first_d = (rd_cnt_q == '0);
      dout_last_d  = rd_last_s;
    end else begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_state_q   <= RD_IDLE;
      rd_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_pending_q <= 1'b0;
      pend_bank_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_state_q   <= rd_state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_bank_q    <= rd_bank_d;
      rd_pending_q <= rd_pending_d;
      pend_bank_q  <= pend_bank_d;
      frame_drop_q <= frame_drop_d;
      dout_valid_q <= dout_valid_d;
      dout_first_q <= dout_first_d;
      dout_last_q  <= dout_last_d;
    end
  end

  fft_sdp_ram #(
    .DEPTH (2 * int'(FFT_SIZE)),
    .WIDTH (DW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.din_valid),
    .waddr ({wr_bank_q, wr_addr_s}),
    .wdata (bus.din),
    .re    (rd_state_q == RD_READ),
    .raddr ({rd_bank_q, rd_cnt_q}),
    .rdata (ram_rdata_s)
  );

  assign bus.dout       = ram_rdata_s;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_first = dout_first_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.frame_drop = frame_drop_q;

endmodule
